// File: rtl/usb_rx_pattern_checker_pkg.sv
// Shared types and constants for the USB EP2 rx pattern checker.
// Stream words are {lo+1, lo}, with lo stepping by two from word to word.
package usb_rx_pattern_checker_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned WCNT_W   = 32;
  localparam int unsigned ECNT_W   = 16;
  localparam int unsigned GSTATE_W = 4;
  localparam int unsigned RUN_W    = 4;

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  localparam logic [GSTATE_W-1:0] GSTATE_HUNT = 4'b0001;
  localparam logic [GSTATE_W-1:0] GSTATE_LOCK = 4'b0010;
  localparam logic [BYTE_W-1:0]   BYTE_STEP   = 8'd2;

  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } rx_word_t;

  // Even low byte with the high byte one above it (mod 256).
  function automatic logic is_well_formed(input rx_word_t w);
    return (w.lo[0] == 1'b0) && (w.hi == (w.lo + 8'd1));
  endfunction

endpackage

// File: rtl/usb_rx_pattern_checker_sat_counter.sv
// Up-counter with synchronous clear (clear wins over increment) and
// optional saturation at all-ones; without saturation it wraps.
module usb_sat_counter #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(SAT_EN && (&cnt_q))) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/usb_rx_pattern_checker.sv
// Checks the incrementing byte-pair test pattern read from EP2: hunts for a
// run of matching words, then counts and flags mismatches while locked.
module usb_rx_pattern_checker
  import usb_rx_pattern_checker_pkg::*;
#(
  parameter int unsigned LOCK_WORDS = 4,
  parameter int unsigned LOSE_ERRS  = 3
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  input  logic                clr,
  output logic                locked,
  output logic                err_flag,
  output logic [WCNT_W-1:0]   word_cnt,
  output logic [ECNT_W-1:0]   err_cnt,
  output logic [GSTATE_W-1:0] gstate,
  output logic                led
);

  state_e               state_q, state_d;
  logic [BYTE_W-1:0]    exp_q, exp_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [RUN_W-1:0]     miss_q, miss_d;
  logic                 err_flag_q, err_flag_d;
  logic                 locked_q, locked_d;
  logic [GSTATE_W-1:0]  gstate_q, gstate_d;
  logic                 led_q, led_d;
  logic                 err_inc_c;
  rx_word_t             word_c;
  logic                 well_formed_c;
  logic                 match_c;

  assign word_c        = rx_word_t'(rx_data);
  assign well_formed_c = is_well_formed(word_c);
  assign match_c       = well_formed_c && (word_c.lo == exp_q);

  // Next-state, expected-byte tracking and registered output decode.
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    run_d      = run_q;
    miss_d     = miss_q;
    err_flag_d = err_flag_q;
    err_inc_c  = 1'b0;

    if (rx_valid) begin
      case (state_q)
        ST_HUNT: begin
          // Any well-formed word restarts the run unless it continues it.
          if (well_formed_c && ((run_q == '0) || !match_c)) begin
            exp_d = word_c.lo + BYTE_STEP;
            run_d = RUN_W'(1);
          end else if (match_c) begin
            exp_d = exp_q + BYTE_STEP;
            run_d = run_q + RUN_W'(1);
          end else begin
            run_d = '0;
          end
          if (run_d == RUN_W'(LOCK_WORDS)) begin
            state_d = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (match_c) begin
            exp_d  = exp_q + BYTE_STEP;
            miss_d = '0;
          end else begin
            err_inc_c  = 1'b1;
            err_flag_d = 1'b1;
            miss_d     = miss_q + RUN_W'(1);
            exp_d      = well_formed_c ? (word_c.lo + BYTE_STEP) : (exp_q + BYTE_STEP);
            if (miss_d == RUN_W'(LOSE_ERRS)) begin
              state_d = ST_HUNT;
              run_d   = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (clr) begin
      err_flag_d = 1'b0;
    end

    locked_d = (state_d == ST_LOCK);
    gstate_d = locked_d ? GSTATE_LOCK : GSTATE_HUNT;
    led_d    = locked_d && !err_flag_d;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      exp_q      <= '0;
      run_q      <= '0;
      miss_q     <= '0;
      err_flag_q <= 1'b0;
      locked_q   <= 1'b0;
      gstate_q   <= GSTATE_HUNT;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      err_flag_q <= err_flag_d;
      locked_q   <= locked_d;
      gstate_q   <= gstate_d;
      led_q      <= led_d;
    end
  end

  usb_sat_counter #(
    .WIDTH  (WCNT_W),
    .SAT_EN (1'b0)
  ) u_word_cnt (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .inc_i (rx_valid),
    .clr_i (clr),
    .cnt_o (word_cnt)
  );

  usb_sat_counter #(
    .WIDTH  (ECNT_W),
    .SAT_EN (1'b1)
  ) u_err_cnt (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .inc_i (err_inc_c),
    .clr_i (clr),
    .cnt_o (err_cnt)
  );

  assign locked   = locked_q;
  assign err_flag = err_flag_q;
  assign gstate   = gstate_q;
  assign led      = led_q;

endmodule

// File: doc/usb_rx_pattern_checker.md
USB_RX_PATTERN_CHECKER -- requirements
Module: usb_rx_pattern_checker

Interface
REQ-001 The block SHALL have the parameter LOCK_WORDS, default 4: the number of consecutive matching words required to enter LOCK (legal range 2..15).
REQ-002 The block SHALL have the parameter LOSE_ERRS, default 3: the number of consecutive mismatches in LOCK that forces a return to HUNT (legal range 1..15).
REQ-003 The block SHALL have the port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port rx_data, input, 16 bits: a word read from EP2 over the slave-FIFO bus, with {hi byte, lo byte}.
REQ-006 The block SHALL have the port rx_valid, input, 1 bit: rx_data holds a word accepted this cycle (slrd low with EP2 not empty).
REQ-007 The block SHALL have the port clr, input, 1 bit: synchronous clear of the counters and the sticky flag.
REQ-008 The block SHALL have the port locked, output, 1 bit: high while the FSM is in LOCK.
REQ-009 The block SHALL have the port err_flag, output, 1 bit: sticky, set on any mismatch in LOCK.
REQ-010 The block SHALL have the port word_cnt, output, 32 bits: the total number of valid words received.
REQ-011 The block SHALL have the port err_cnt, output, 16 bits: the number of mismatched words in LOCK.
REQ-012 The block SHALL have the port gstate, output, 4 bits: the debug state code.
REQ-013 The block SHALL have the port led, output, 1 bit: equal to locked AND NOT err_flag.

Function
REQ-014 A word SHALL be well-formed when lo[0]==0 and hi==lo+1 (mod 256).
REQ-015 A word SHALL match when it is well-formed and lo equals exp (an 8-bit register).
REQ-016 All outputs SHALL be registered, with 1-cycle latency from the rx_valid edge to the updated outputs.
REQ-017 Only cycles with rx_valid=1 SHALL affect the FSM, exp or counters, except clr.
REQ-018 On every rx_valid the block SHALL increment word_cnt, wrapping modulo 2^32 (FFFFFFFF -> 0).
REQ-019 The FSM SHALL have two states, HUNT and LOCK; gstate SHALL be 4'b0001 in HUNT and 4'b0010 in LOCK.
REQ-020 In HUNT, a match SHALL advance exp by 2 and increment run.
REQ-021 In HUNT, a well-formed non-match SHALL set exp=lo+2 and run=1.
REQ-022 In HUNT, a malformed word SHALL clear run to 0.
REQ-023 In HUNT, reaching run==LOCK_WORDS SHALL move the FSM to LOCK, with locked high on the next cycle; the run counter is 4 bits.
REQ-024 In HUNT, when run==0, any well-formed word SHALL seed exp=lo+2 and set run=1.
REQ-025 In HUNT, err_cnt and err_flag SHALL NOT change.
REQ-026 In LOCK, a match SHALL advance exp by 2 and clear miss.
REQ-027 In LOCK, a mismatch SHALL increment err_cnt (saturating at FFFF), set err_flag, and increment miss.
REQ-028 In LOCK, a mismatch SHALL set exp to lo+2 if the word is well-formed, else to exp+2.
REQ-029 In LOCK, reaching miss==LOSE_ERRS SHALL move the FSM to HUNT and clear run and miss.
REQ-030 exp arithmetic SHALL be 8-bit and wrap (FE+2 -> 00); the wrap SHALL NOT count as an error.
REQ-031 clr SHALL zero word_cnt and err_cnt, clear err_flag, and leave the FSM, exp, run and miss unchanged.
REQ-032 When clr and rx_valid are both high, clr SHALL win for the counters and flag (the word is not counted), while the FSM and exp still process the word.

Reset
REQ-033 rst_n low SHALL asynchronously force HUNT, exp=0, run=0, miss=0, word_cnt=0, err_cnt=0, err_flag=0, locked=0, gstate=4'b0001, and led=0.
REQ-034 Reset release SHALL be synchronised by the integrator; the block SHALL accept rx_valid from the first clock after rst_n rises.
REQ-035 Reset asserted mid-stream SHALL discard all state, and relock SHALL require LOCK_WORDS new matches.

Structure
REQ-036 A shared package SHALL hold the FSM state enumeration, the gstate codes (0001, 0010), and the byte step constant 2.
REQ-037 One sub-module, usb_sat_counter (parameterised width, inc, clr, saturate enable), SHALL be used for err_cnt, with saturation on, and for word_cnt, with saturation off.

Verification
REQ-038 The bench SHALL cover: reset, then words 0100,0302,0504,0706 with rx_valid -> locked=1 one cycle after the 4th word, word_cnt=4, err_cnt=0, led=1.
REQ-039 The bench SHALL cover: locked at exp=FE, then words FFFE,0100 -> no error, exp=02, locked stays 1.
REQ-040 The bench SHALL cover: locked, then a single word 1234 followed by correctly continuing words -> err_cnt=1, err_flag=1, led=0, locked stays 1.
REQ-041 The bench SHALL cover: locked, then 3 consecutive malformed words (e.g. AAAA) -> err_cnt=3 and locked=0 after the 3rd; then 4 good sequential words -> locked=1, err_flag still 1.
REQ-042 The bench SHALL cover: clr pulsed together with rx_valid in LOCK -> word_cnt=0, err_cnt=0, err_flag=0 next cycle, while locked is unchanged.
REQ-043 The bench SHALL cover: err_cnt preloaded to FFFF via forced mismatches -> a further mismatch keeps FFFF; rst_n pulsed low mid-stream -> all outputs are at reset values immediately, asynchronously.
